// File: rtl/vga_rx_decoder.sv
// vga_rx_decoder: sink-side decoder for the VGA pixel stream. It recovers pixel coordinates, checks sync timing and locks to the frame structure.
// Optional frame CRC: define VGA_RX_CRC_EN (undefined: frame_crc tied 0).
module vga_rx_decoder #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_START  = 144,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_START  = 35,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_TOTAL  = 525
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs,
  input  logic        vs,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        frame_done,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [7:0]  err_cnt,
  output logic [15:0] frame_crc
);

  // state    | meaning
  // UNLOCKED | no frame structure seen, waiting for a VS fall
  // ACQUIRE  | one VS fall seen, watching one clean frame
  // LOCKED   | timing verified, pixels and frame_done reported
  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  localparam logic [10:0] H_SYNC_W  = 11'(H_SYNC);
  localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
  localparam logic [10:0] V_SYNC_W  = 11'(V_SYNC);
  localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
  localparam logic [9:0]  HA_LO = 10'(H_START);
  localparam logic [9:0]  HA_HI = 10'(H_START + H_ACTIVE);
  localparam logic [9:0]  VA_LO = 10'(V_START);
  localparam logic [9:0]  VA_HI = 10'(V_START + V_ACTIVE);

  logic        hs_q, vs_q, hs_p, vs_p;
  logic [11:0] rgb_q, rgb_d;
  logic [9:0]  h_cnt, v_cnt, v_next;
  logic        vs_pend, line_seen, frame_seen;
  logic        h_ev, v_ev, vsf_d;
  logic        hs_fall, hs_rise, vs_fall, vs_rise;
  logic [10:0] h_len, v_len;
  logic        h_bad, v_bad, active, err_now;
  state_t      state, state_nx;
  logic        acq_bad, acq_bad_nx, done_nx;

  assign hs_fall = hs_p & ~hs_q;
  assign hs_rise = ~hs_p & hs_q;
  assign vs_fall = vs_p & ~vs_q;
  assign vs_rise = ~vs_p & vs_q;
  assign h_len   = {1'b0, h_cnt} + 11'd1;
  assign v_len   = {1'b0, v_cnt} + 11'd1;

  always_comb begin
    v_next = v_cnt;
    if (hs_fall) begin
      if (vs_pend || vs_fall) v_next = '0;
      else if (v_cnt != 10'h3FF) v_next = v_cnt + 10'd1;
    end
  end

  // The first line/frame after reset is a fragment, so its length is not judged.
  assign h_bad = line_seen && ((hs_fall && h_len != H_TOTAL_W) || (hs_rise && h_len != H_SYNC_W));
  assign v_bad = frame_seen && ((vs_fall && v_len != V_TOTAL_W) ||
                                (vs_rise && {1'b0, v_next} != V_SYNC_W));
  assign active = (h_cnt >= HA_LO) && (h_cnt < HA_HI) && (v_cnt >= VA_LO) && (v_cnt < VA_HI);
  assign err_now = h_ev | v_ev;

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q <= 1'b1; vs_q <= 1'b1; hs_p <= 1'b1; vs_p <= 1'b1;
      rgb_q <= '0; rgb_d <= '0;
      h_cnt <= '0; v_cnt <= '0;
      vs_pend <= 1'b0; line_seen <= 1'b0; frame_seen <= 1'b0;
      h_ev <= 1'b0; v_ev <= 1'b0; vsf_d <= 1'b0;
    end else begin
      hs_q  <= hs;   vs_q <= vs;
      hs_p  <= hs_q; vs_p <= vs_q;
      rgb_q <= {r, g, b};
      rgb_d <= rgb_q;
      if (hs_fall) h_cnt <= '0;
      else if (h_cnt != 10'h3FF) h_cnt <= h_cnt + 10'd1;
      v_cnt <= v_next;
      if (hs_fall) vs_pend <= 1'b0;
      else if (vs_fall) vs_pend <= 1'b1;
      if (hs_fall) line_seen <= 1'b1;
      if (vs_fall) frame_seen <= 1'b1;
      h_ev  <= h_bad;
      v_ev  <= v_bad;
      vsf_d <= vs_fall;
    end
  end

  always_comb begin
    state_nx   = state;
    acq_bad_nx = acq_bad;
    done_nx    = 1'b0;
    case (state)
      UNLOCKED: if (vsf_d) begin
        state_nx   = ACQUIRE;
        acq_bad_nx = 1'b0;
      end
      ACQUIRE: begin
        if (vsf_d) begin
          if (!(acq_bad || err_now)) state_nx = LOCKED;
          acq_bad_nx = 1'b0;
        end else if (err_now) begin
          acq_bad_nx = 1'b1;
        end
      end
      LOCKED: begin
        done_nx = vsf_d;
        if (err_now) state_nx = UNLOCKED;
      end
      default: state_nx = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= UNLOCKED; acq_bad <= 1'b0; frame_done <= 1'b0;
      h_err <= 1'b0; v_err <= 1'b0; err_cnt <= '0;
      pix_valid <= 1'b0; pix_x <= '0; pix_y <= '0; pix_rgb <= '0;
    end else begin
      state      <= state_nx;
      acq_bad    <= acq_bad_nx;
      frame_done <= done_nx;
      h_err      <= h_err | h_ev;
      v_err      <= v_err | v_ev;
      if (state == LOCKED && err_now && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      pix_valid <= (state == LOCKED) && active;
      pix_x     <= ((state == LOCKED) && active) ? h_cnt - HA_LO : '0;
      pix_y     <= ((state == LOCKED) && active) ? 9'(v_cnt - VA_LO) : '0;
      pix_rgb   <= ((state == LOCKED) && active) ? rgb_d : '0;
    end
  end

  assign locked = (state == LOCKED);

`ifdef VGA_RX_CRC_EN
  logic [15:0] crc;

  // CRC-16-CCITT, 12 data bits per clock, MSB first.
  function automatic logic [15:0] crc_step(input logic [15:0] crc_in, input logic [11:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 11; i >= 0; i--) c = {c[14:0], 1'b0} ^ ((c[15] ^ data[i]) ? 16'h1021 : 16'h0000);
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      crc       <= 16'hFFFF;
      frame_crc <= '0;
    end else begin
      if (vsf_d) crc <= 16'hFFFF;
      else if (pix_valid) crc <= crc_step(crc, pix_rgb);
      if (done_nx) frame_crc <= crc;
    end
  end
`else
  assign frame_crc = '0;
`endif

endmodule
